// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Saturates to all nines and flags overflow when the input exceeds DIGITS decimal digits.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int CMP_W = (BIN_W > BCD_W) ? BIN_W : BCD_W;

  // Largest value representable in DIGITS decimal digits; 10^D-1 < 2^(4D), so CMP_W bits suffice.
  function automatic logic [CMP_W-1:0] max_decimal();
    logic [CMP_W-1:0] acc;
    acc = CMP_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      acc = acc * CMP_W'(10);
    end
    return acc - CMP_W'(1);
  endfunction

  localparam logic [CMP_W-1:0] MAX_DEC = max_decimal();

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_cap_q, ovf_cap_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;

  logic [BCD_W-1:0]   adjusted;
  logic [CMP_W-1:0]   bin_ext;

  assign bin_ext = CMP_W'(bin);

  // Add-3 correction on every digit before the shift, all digits in parallel.
  always_comb begin
    adjusted = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        adjusted[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // NOTE: every next-state signal is given its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_cap_d  = ovf_cap_q;
    bcd_d      = bcd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(BIN_W);
          ovf_cap_d = (bin_ext > MAX_DEC);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        scratch_d = {adjusted[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d     = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        bcd_d      = ovf_cap_q ? {DIGITS{4'h9}} : scratch_q;
        overflow_d = ovf_cap_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_cap_q  <= 1'b0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_cap_q  <= ovf_cap_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign bcd      = bcd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule
